// File: rtl/wake_ctrl_pkg.sv
// Shared types and constants for the wake controller and its timer.
package wake_ctrl_pkg;

    localparam int unsigned DATA_W    = 32;
    localparam int unsigned REG_IDX_W = 3;

    // Controller sequencing: awake, asleep and watching for wake, waking the core.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_WAKE  = 2'd2
    } state_t;

    typedef logic [REG_IDX_W-1:0] reg_idx_t;

    // Register word indices, taken from PADDR[4:2].
    localparam reg_idx_t REG_MASK    = 3'd0;
    localparam reg_idx_t REG_PENDING = 3'd1;
    localparam reg_idx_t REG_LOAD    = 3'd2;
    localparam reg_idx_t REG_TCTRL   = 3'd3;
    localparam reg_idx_t REG_TVALUE  = 3'd4;

    // TCTRL field positions.
    localparam int unsigned TCTRL_EN_BIT     = 0;
    localparam int unsigned TCTRL_RELOAD_BIT = 1;

    // Timer control register; packing order matches the bit positions above.
    typedef struct packed {
        logic reload;
        logic en;
    } tctrl_t;

    // Zero-extended software view of TCTRL.
    function automatic logic [DATA_W-1:0] tctrl_word(input tctrl_t t);
        return DATA_W'(t);
    endfunction

endpackage

// File: rtl/wake_ctrl_if.sv
// APB slave bus bundle for the wake controller.
interface wake_ctrl_if #(
    parameter int unsigned APB_ADDR_WIDTH = 12
) ();

    logic [APB_ADDR_WIDTH-1:0] PADDR;
    logic [31:0]               PWDATA;
    logic                      PWRITE;
    logic                      PSEL;
    logic                      PENABLE;
    logic [31:0]               PRDATA;
    logic                      PREADY;
    logic                      PSLVERR;

    modport master (
        output PADDR, PWDATA, PWRITE, PSEL, PENABLE,
        input  PRDATA, PREADY, PSLVERR
    );

    modport slave (
        input  PADDR, PWDATA, PWRITE, PSEL, PENABLE,
        output PRDATA, PREADY, PSLVERR
    );

endinterface

// File: rtl/wake_timer.sv
// Sleep down-counter: loads on arming, counts while armed, flags expiry.
module wake_timer
    import wake_ctrl_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] load_val,
    input  logic              arm,
    input  logic              run,
    input  logic              reload,
    output logic [DATA_W-1:0] value,
    output logic              expire_c,
    output logic              irq
);

    // High during the first armed cycle, so a zero load still expires once.
    logic first_q;

    // Expiry when the count is about to reach zero, or it started at zero.
    always_comb begin
        expire_c = 1'b0;
        if (run) begin
            expire_c = (value == DATA_W'(1)) || (first_q && (value == '0));
        end
    end

    // Count register with load, saturating decrement and optional reload.
    always_ff @(posedge clk) begin
        if (rst) begin
            value   <= '0;
            first_q <= 1'b0;
            irq     <= 1'b0;
        end else begin
            first_q <= arm;
            irq     <= expire_c;
            if (arm) begin
                value <= load_val;
            end else if (expire_c) begin
                value <= reload ? load_val : '0;
            end else if (run && (value != '0)) begin
                value <= value - DATA_W'(1);
            end
        end
    end

endmodule

// File: rtl/wake_ctrl.sv
// Wake controller: APB registers, wake-source edge capture and sleep FSM.
module wake_ctrl
    import wake_ctrl_pkg::*;
#(
    parameter int unsigned APB_ADDR_WIDTH = 12,
    parameter int unsigned NUM_SRC        = 8
) (
    input  logic               HCLK,
    input  logic               HRESET,
    wake_ctrl_if.slave         apb,
    input  logic [NUM_SRC-1:0] wake_src_i,
    input  logic               sleeping_i,
    output logic               event_o,
    output logic               timer_irq_o
);

    // The timer owns the bit just above the external sources.
    localparam int unsigned PEND_W = NUM_SRC + 1;

    reg_idx_t           idx_c;
    logic               wr_c;
    logic               rd_c;
    logic               unused_addr;

    logic [PEND_W-1:0]  mask_q;
    logic [PEND_W-1:0]  pending_q;
    logic [PEND_W-1:0]  set_c;
    logic [PEND_W-1:0]  w1c_c;
    logic [NUM_SRC-1:0] src_q;
    logic [NUM_SRC-1:0] rise_c;
    logic [DATA_W-1:0]  load_q;
    tctrl_t             tctrl_q;
    logic [DATA_W-1:0]  tvalue;
    logic               expire_c;
    logic [DATA_W-1:0]  rd_data_c;

    state_t             state_q;
    state_t             state_next_c;
    logic               arm_c;
    logic               run_c;
    logic               event_next_c;
    logic               event_q;

    assign idx_c       = apb.PADDR[4:2];
    assign wr_c        = apb.PSEL & apb.PENABLE & apb.PWRITE;
    assign rd_c        = apb.PSEL & apb.PENABLE & ~apb.PWRITE;
    assign unused_addr = ^{apb.PADDR[APB_ADDR_WIDTH-1:5], apb.PADDR[1:0]};

    assign apb.PREADY  = 1'b1;
    assign apb.PSLVERR = 1'b0;
    assign apb.PRDATA  = rd_data_c;
    assign event_o     = event_q;

    // Pending set sources and software write-one-to-clear mask.
    always_comb begin
        rise_c = wake_src_i & ~src_q;
        set_c  = {expire_c, rise_c};
        w1c_c  = '0;
        if (wr_c && (idx_c == REG_PENDING)) begin
            w1c_c = apb.PWDATA[PEND_W-1:0];
        end
    end

    // Software registers, source sampling and pending bits (set beats clear).
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            mask_q    <= '0;
            pending_q <= '0;
            src_q     <= '0;
            load_q    <= '0;
            tctrl_q   <= '0;
        end else begin
            src_q     <= wake_src_i;
            pending_q <= (pending_q & ~w1c_c) | set_c;
            if (wr_c) begin
                case (idx_c)
                    REG_MASK:  mask_q <= apb.PWDATA[PEND_W-1:0];
                    REG_LOAD:  load_q <= apb.PWDATA;
                    REG_TCTRL: begin
                        tctrl_q.en     <= apb.PWDATA[TCTRL_EN_BIT];
                        tctrl_q.reload <= apb.PWDATA[TCTRL_RELOAD_BIT];
                    end
                    default:   ;
                endcase
            end
        end
    end

    // Read mux; the bus reads zero outside a read access phase.
    always_comb begin
        rd_data_c = '0;
        if (rd_c) begin
            case (idx_c)
                REG_MASK:    rd_data_c = DATA_W'(mask_q);
                REG_PENDING: rd_data_c = DATA_W'(pending_q);
                REG_LOAD:    rd_data_c = load_q;
                REG_TCTRL:   rd_data_c = tctrl_word(tctrl_q);
                REG_TVALUE:  rd_data_c = tvalue;
                default:     rd_data_c = '0;
            endcase
        end
    end

    // Sleep FSM state and registered wake event.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state_q <= ST_IDLE;
            event_q <= 1'b0;
        end else begin
            state_q <= state_next_c;
            event_q <= event_next_c;
        end
    end

    // Next-state, timer arm/run controls and event decode.
    always_comb begin
        state_next_c = state_q;
        arm_c        = 1'b0;
        run_c        = 1'b0;
        event_next_c = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (sleeping_i) begin
                    state_next_c = ST_ARMED;
                    arm_c        = tctrl_q.en;
                end
            end
            ST_ARMED: begin
                run_c = tctrl_q.en;
                if (|(pending_q & mask_q)) begin
                    state_next_c = ST_WAKE;
                end else if (!sleeping_i) begin
                    state_next_c = ST_IDLE;
                end
            end
            ST_WAKE: begin
                if (!sleeping_i) begin
                    state_next_c = ST_IDLE;
                end
            end
            default: state_next_c = ST_IDLE;
        endcase
        event_next_c = (state_next_c == ST_WAKE);
    end

    // Sleep timer.
    wake_timer u_timer (
        .clk      (HCLK),
        .rst      (HRESET),
        .load_val (load_q),
        .arm      (arm_c),
        .run      (run_c),
        .reload   (tctrl_q.reload),
        .value    (tvalue),
        .expire_c (expire_c),
        .irq      (timer_irq_o)
    );

endmodule

// File: tb/tb_wake_ctrl.sv
// Self-checking bench for wake_ctrl: register table, random pending model, directed sleep scenarios.
module tb_wake_ctrl;

    localparam int unsigned NSRC = 8;

    logic            HCLK = 1'b0;
    logic            HRESET;
    logic [NSRC-1:0] wake_src;
    logic            sleeping;
    logic            event_w;
    logic            irq_w;

    int checks = 0;
    int errors = 0;

    wake_ctrl_if #(.APB_ADDR_WIDTH(12)) apb ();

    wake_ctrl #(
        .APB_ADDR_WIDTH (12),
        .NUM_SRC        (NSRC)
    ) dut (
        .HCLK        (HCLK),
        .HRESET      (HRESET),
        .apb         (apb),
        .wake_src_i  (wake_src),
        .sleeping_i  (sleeping),
        .event_o     (event_w),
        .timer_irq_o (irq_w)
    );

    always #5 HCLK = ~HCLK;

    typedef struct {
        logic [11:0] waddr;
        logic [31:0] wdata;
        logic [11:0] raddr;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs [11];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge HCLK);
        #1;
    endtask

    task automatic bus_idle();
        apb.PSEL    = 1'b0;
        apb.PENABLE = 1'b0;
        apb.PWRITE  = 1'b0;
        apb.PADDR   = '0;
        apb.PWDATA  = '0;
    endtask

    task automatic apb_write(input logic [11:0] addr, input logic [31:0] data);
        apb.PADDR   = addr;
        apb.PWDATA  = data;
        apb.PWRITE  = 1'b1;
        apb.PSEL    = 1'b1;
        apb.PENABLE = 1'b0;
        tick();
        apb.PENABLE = 1'b1;
        tick();
        bus_idle();
    endtask

    // Zero-time read access; consumes no clock edge.
    task automatic peek(input logic [11:0] addr, output logic [31:0] data);
        apb.PADDR   = addr;
        apb.PWRITE  = 1'b0;
        apb.PSEL    = 1'b1;
        apb.PENABLE = 1'b1;
        #1;
        data = apb.PRDATA;
        bus_idle();
    endtask

    task automatic peek_check(input string name, input logic [11:0] addr, input logic [31:0] exp);
        logic [31:0] d;
        peek(addr, d);
        check(name, d, exp);
    endtask

    task automatic do_reset();
        wake_src = '0;
        sleeping = 1'b0;
        bus_idle();
        HRESET = 1'b1;
        tick();
        HRESET = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic [8:0]      m_pend;
        logic [NSRC-1:0] m_prev;
        logic [31:0]     d;

        vecs[0]  = '{12'h000, 32'hFFFF_FFFF, 12'h000, 32'h0000_01FF};
        vecs[1]  = '{12'h008, 32'hDEAD_BEEF, 12'h008, 32'hDEAD_BEEF};
        vecs[2]  = '{12'h00C, 32'hFFFF_FFFF, 12'h00C, 32'h0000_0003};
        vecs[3]  = '{12'h014, 32'h1234_5678, 12'h014, 32'h0000_0000};
        vecs[4]  = '{12'h010, 32'h0000_AAAA, 12'h010, 32'h0000_0000};
        vecs[5]  = '{12'h004, 32'hFFFF_FFFF, 12'h004, 32'h0000_0000};
        vecs[6]  = '{12'h000, 32'h0000_00A5, 12'h000, 32'h0000_00A5};
        vecs[7]  = '{12'h01C, 32'hFFFF_FFFF, 12'h018, 32'h0000_0000};
        vecs[8]  = '{12'h00C, 32'h0000_0002, 12'h00C, 32'h0000_0002};
        vecs[9]  = '{12'h008, 32'h0000_0000, 12'h008, 32'h0000_0000};
        vecs[10] = '{12'h028, 32'h0000_0055, 12'h008, 32'h0000_0055};

        // Reset state
        HRESET = 1'b1;
        wake_src = '0;
        sleeping = 1'b0;
        bus_idle();
        repeat (2) tick();
        HRESET = 1'b0;
        check("rst_event", 32'(event_w), 32'd0);
        check("rst_irq", 32'(irq_w), 32'd0);
        check("pready", 32'(apb.PREADY), 32'd1);
        check("pslverr", 32'(apb.PSLVERR), 32'd0);
        for (int i = 0; i < 5; i++) begin
            peek_check($sformatf("rst_reg%0d", i), 12'(i * 4), 32'd0);
        end

        // Register access table
        for (int i = 0; i < 11; i++) begin
            apb_write(vecs[i].waddr, vecs[i].wdata);
            peek_check($sformatf("vec%0d", i), vecs[i].raddr, vecs[i].exp);
        end

        // PRDATA gating outside a read access phase
        apb.PADDR = 12'h008; apb.PSEL = 1'b1; apb.PENABLE = 1'b0; apb.PWRITE = 1'b0;
        #1 check("prdata_setup", apb.PRDATA, 32'd0);
        apb.PENABLE = 1'b1; apb.PWRITE = 1'b1;
        #1 check("prdata_write", apb.PRDATA, 32'd0);
        apb.PWRITE = 1'b0;
        #1 check("prdata_read", apb.PRDATA, 32'h55);
        bus_idle();

        // Random sources and W1C against a bitmask model, core awake
        do_reset();
        m_pend = '0;
        m_prev = '0;
        for (int it = 0; it < 200; it++) begin
            logic [NSRC-1:0] s;
            logic [31:0]     clr;
            s = NSRC'($urandom);
            wake_src = s;
            tick();
            m_pend = m_pend | {1'b0, s & ~m_prev};
            m_prev = s;
            if ($urandom_range(0, 3) == 0) begin
                clr = $urandom;
                apb_write(12'h004, clr);
                m_pend = m_pend & ~clr[8:0];
            end
            peek_check("rand_pending", 12'h004, 32'(m_pend));
            if ($urandom_range(0, 7) == 0) begin
                clr = $urandom;
                apb_write(12'h000, clr);
                peek_check("rand_mask", 12'h000, {23'd0, clr[8:0]});
            end
            check("rand_event", 32'(event_w), 32'd0);
        end

        // S1: external source wakes, event holds until the core is awake
        do_reset();
        apb_write(12'h000, 32'h1);
        sleeping = 1'b1;
        tick();
        check("s1_armed_event", 32'(event_w), 32'd0);
        wake_src[0] = 1'b1;
        tick();
        wake_src[0] = 1'b0;
        peek_check("s1_pending", 12'h004, 32'h001);
        check("s1_event_pre", 32'(event_w), 32'd0);
        tick();
        check("s1_event_on", 32'(event_w), 32'd1);
        repeat (3) tick();
        check("s1_event_hold", 32'(event_w), 32'd1);
        sleeping = 1'b0;
        tick();
        check("s1_event_off", 32'(event_w), 32'd0);
        tick();
        check("s1_idle", 32'(event_w), 32'd0);

        // S2: one-shot timer wake
        do_reset();
        apb_write(12'h000, 32'h100);
        apb_write(12'h008, 32'd5);
        apb_write(12'h00C, 32'h1);
        sleeping = 1'b1;
        tick();
        peek_check("s2_tvalue_load", 12'h010, 32'd5);
        for (int i = 1; i <= 7; i++) begin
            tick();
            check($sformatf("s2_irq_%0d", i), 32'(irq_w), (i == 5) ? 32'd1 : 32'd0);
            check($sformatf("s2_event_%0d", i), 32'(event_w), (i >= 6) ? 32'd1 : 32'd0);
        end
        peek_check("s2_pending", 12'h004, 32'h100);
        peek_check("s2_tvalue_end", 12'h010, 32'd0);

        // S3: periodic reload timer, masked so no wake
        do_reset();
        apb_write(12'h008, 32'd3);
        apb_write(12'h00C, 32'h3);
        sleeping = 1'b1;
        tick();
        for (int i = 1; i <= 12; i++) begin
            tick();
            check($sformatf("s3_irq_%0d", i), 32'(irq_w), (i % 3 == 0) ? 32'd1 : 32'd0);
            check($sformatf("s3_event_%0d", i), 32'(event_w), 32'd0);
        end
        peek_check("s3_pending", 12'h004, 32'h100);

        // S4: set wins over same-cycle W1C
        do_reset();
        wake_src[2] = 1'b1;
        tick();
        wake_src[2] = 1'b0;
        tick();
        peek_check("s4_set", 12'h004, 32'h4);
        apb_write(12'h004, 32'h4);
        peek_check("s4_w1c", 12'h004, 32'h0);
        apb.PADDR = 12'h004; apb.PWDATA = 32'h4; apb.PWRITE = 1'b1;
        apb.PSEL = 1'b1; apb.PENABLE = 1'b0;
        tick();
        apb.PENABLE = 1'b1;
        wake_src[2] = 1'b1;
        tick();
        bus_idle();
        wake_src[2] = 1'b0;
        peek_check("s4_set_wins", 12'h004, 32'h4);

        // S5: external wake freezes timer; clearing EN while armed freezes it too
        do_reset();
        apb_write(12'h008, 32'd20);
        apb_write(12'h00C, 32'h1);
        apb_write(12'h000, 32'h1FF);
        sleeping = 1'b1;
        tick();
        repeat (4) tick();
        peek_check("s5_tvalue_run", 12'h010, 32'd16);
        sleeping = 1'b0;
        tick();
        check("s5_event", 32'(event_w), 32'd0);
        peek_check("s5_tvalue_stop", 12'h010, 32'd15);
        repeat (3) tick();
        peek_check("s5_tvalue_frozen", 12'h010, 32'd15);
        check("s5_event_idle", 32'(event_w), 32'd0);
        sleeping = 1'b1;
        tick();
        apb_write(12'h00C, 32'h0);
        repeat (3) tick();
        peek_check("s5_en_freeze", 12'h010, 32'd18);
        sleeping = 1'b0;
        tick();

        // S7: zero load expires on the first armed cycle
        do_reset();
        apb_write(12'h00C, 32'h1);
        sleeping = 1'b1;
        tick();
        check("s7_irq_0", 32'(irq_w), 32'd0);
        tick();
        check("s7_irq_1", 32'(irq_w), 32'd1);
        tick();
        check("s7_irq_2", 32'(irq_w), 32'd0);
        tick();
        check("s7_irq_3", 32'(irq_w), 32'd0);

        // S6: pending at arming wakes one cycle later; reset in WAKE clears all
        do_reset();
        apb_write(12'h000, 32'h1);
        apb_write(12'h008, 32'h77);
        apb_write(12'h00C, 32'h3);
        wake_src[0] = 1'b1;
        tick();
        wake_src[0] = 1'b0;
        tick();
        sleeping = 1'b1;
        tick();
        check("s6_event_arm", 32'(event_w), 32'd0);
        tick();
        check("s6_event_wake", 32'(event_w), 32'd1);
        HRESET = 1'b1;
        tick();
        HRESET = 1'b0;
        sleeping = 1'b0;
        check("s6_rst_event", 32'(event_w), 32'd0);
        check("s6_rst_irq", 32'(irq_w), 32'd0);
        for (int i = 0; i < 5; i++) begin
            peek_check($sformatf("s6_rst_reg%0d", i), 12'(i * 4), 32'd0);
        end
        tick();
        check("s6_stay_idle", 32'(event_w), 32'd0);

        d = '0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/wake_ctrl.md
WAKE_CTRL -- requirements
Module: wake_ctrl

Interface
REQ-001 SHALL have parameter APB_ADDR_WIDTH, default 12, APB slave address width.
REQ-002 SHALL have parameter NUM_SRC, default 8, number of external wake sources (1..16).
REQ-003 SHALL have one clock and a synchronous active-high reset: HCLK input 1, the single clock; HRESET input 1, synchronous active-high reset.
REQ-004 SHALL have APB slave ports:
- PADDR input APB_ADDR_WIDTH
- PWDATA input 32
- PWRITE input 1
- PSEL input 1
- PENABLE input 1
- PRDATA output 32
- PREADY output 1
- PSLVERR output 1
REQ-005 SHALL have wake_src_i input NUM_SRC: synchronous level wake sources.
REQ-006 SHALL have sleeping_i input 1: sleep unit status, high while the core clock is gated.
REQ-007 SHALL have event_o output 1: wake event to the sleep unit event input.
REQ-008 SHALL have timer_irq_o output 1: one-cycle pulse on timer expiry.

Function
REQ-009 SHALL tie PREADY=1 and PSLVERR=0; PRDATA=0 unless PSEL&&PENABLE&&!PWRITE.
REQ-010 SHALL decode word index PADDR[4:2]. Registers:
- 0 MASK (RW, NUM_SRC+1 bits; bit NUM_SRC=timer)
- 1 PENDING (R, W1C)
- 2 LOAD (RW, 32b)
- 3 TCTRL (RW; bit0 EN, bit1 RELOAD)
- 4 TVALUE (RO)
REQ-011 SHALL return 0 on reads of undefined indices and ignore writes to them; unused register bits SHALL read 0.
REQ-012 SHALL register wake_src_i once and set PENDING[i] on each 0->1 edge, independent of MASK.
REQ-013 SHALL give set priority over a same-cycle W1C clear of the same PENDING bit.
REQ-014 SHALL implement FSM states IDLE, ARMED, WAKE; next-state is registered.
REQ-015 IDLE: event_o=0. On sleeping_i=1, SHALL go to ARMED and, if TCTRL.EN, load TVALUE<=LOAD in that cycle.
REQ-016 ARMED transitions:
- if |(PENDING&MASK) SHALL go to WAKE next cycle;
- else if sleeping_i=0 (external wake), SHALL go to IDLE with the timer frozen.
REQ-017 ARMED timer: with TCTRL.EN, TVALUE SHALL decrement by 1 per cycle, saturating at 0.
REQ-018 Timer expiry in ARMED (TVALUE==1, or TVALUE==0 on the arming cycle) SHALL set PENDING[NUM_SRC], pulse timer_irq_o for 1 cycle, and reload TVALUE<=LOAD if TCTRL.RELOAD, else hold 0.
REQ-019 WAKE: event_o=1 (registered, asserted the cycle after the ARMED->WAKE decision). SHALL return to IDLE on the first cycle sleeping_i=0.
REQ-020 Masked pending already set on entry to ARMED SHALL cause WAKE exactly one cycle later.
REQ-021 The timer SHALL not count in IDLE or WAKE.
REQ-022 Clearing TCTRL.EN in ARMED SHALL freeze TVALUE immediately.
REQ-023 A MASK write SHALL take effect on the next cycle's wake evaluation.
REQ-024 APB writes SHALL update registers one cycle after the PENABLE cycle; they never stall.

Reset
REQ-025 On HRESET=1 at a HCLK edge: state=IDLE; all registers, edge-sample flops, event_o and timer_irq_o SHALL be 0.
REQ-026 Reset asserted mid-ARMED or mid-WAKE SHALL drop event_o the following cycle and discard pending bits.

Structure
REQ-027 Package wake_ctrl_pkg SHALL hold the state enum, register word indices, and TCTRL bit positions.
REQ-028 The down-counter (load, decrement, saturate, reload, expiry pulse) SHALL be sub-module wake_timer; the rest is in wake_ctrl.

Verification
REQ-029 Bench SHALL cover the following directed scenarios:
- MASK=0x01; sleeping_i=1; pulse wake_src_i[0] -> PENDING=0x001, event_o=1 until sleeping_i=0, then IDLE.
- MASK=0x100, LOAD=5, TCTRL=1; sleeping_i=1 -> timer_irq_o pulses 5 cycles after arming, event_o next cycle, PENDING=0x100.
- LOAD=3, TCTRL=3, MASK=0; stay asleep 10 cycles -> timer_irq_o every 3 cycles, event_o stays 0.
- W1C PENDING bit 2 on the same cycle as a wake_src_i[2] rising edge -> PENDING[2] remains 1.
- ARMED with timer running, sleeping_i drops -> IDLE, event_o stays 0, TVALUE frozen.
- Reset asserted during WAKE -> event_o=0, all registers read 0 afterwards.
